// File: rtl/chess_pkg.sv
// Shared chess types: 4-bit piece encoding, parser state codes and ASCII piece lookup.
package chess_pkg;

   typedef logic [3:0] piece_t;

   localparam piece_t PT_EMPTY  = 4'd0;
   localparam piece_t PT_PAWN   = 4'd1;
   localparam piece_t PT_KNIGHT = 4'd2;
   localparam piece_t PT_BISHOP = 4'd3;
   localparam piece_t PT_ROOK   = 4'd4;
   localparam piece_t PT_QUEEN  = 4'd5;
   localparam piece_t PT_KING   = 4'd6;
   localparam piece_t PT_BLACK  = 4'd8;

   typedef logic [2:0] fen_state_e;

   localparam fen_state_e ST_IDLE   = 3'd0;
   localparam fen_state_e ST_PLACE  = 3'd1;
   localparam fen_state_e ST_EXPAND = 3'd2;
   localparam fen_state_e ST_SPACE  = 3'd3;
   localparam fen_state_e ST_SIDE   = 3'd4;
   localparam fen_state_e ST_TAIL   = 3'd5;
   localparam fen_state_e ST_DRAIN  = 3'd6;

   // Returns {valid, piece}; lower-case letters are black.
   function automatic logic [4:0] ascii_to_piece(input logic [7:0] c);
      logic [4:0] r;
      unique case (c)
         "P": r = {1'b1, PT_PAWN};
         "N": r = {1'b1, PT_KNIGHT};
         "B": r = {1'b1, PT_BISHOP};
         "R": r = {1'b1, PT_ROOK};
         "Q": r = {1'b1, PT_QUEEN};
         "K": r = {1'b1, PT_KING};
         "p": r = {1'b1, PT_BLACK | PT_PAWN};
         "n": r = {1'b1, PT_BLACK | PT_KNIGHT};
         "b": r = {1'b1, PT_BLACK | PT_BISHOP};
         "r": r = {1'b1, PT_BLACK | PT_ROOK};
         "q": r = {1'b1, PT_BLACK | PT_QUEEN};
         "k": r = {1'b1, PT_BLACK | PT_KING};
         default: r = {1'b0, PT_EMPTY};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fen_char_decode.sv
// Combinational classifier for one FEN byte.
module fen_char_decode
   import chess_pkg::*;
(
   input  logic [7:0] data,
   output logic       is_piece,
   output piece_t     piece,
   output logic       is_digit,
   output logic [3:0] count,
   output logic       is_slash,
   output logic       is_space,
   output logic       is_side,
   output logic       stm
);

   logic [4:0] lookup;

   always_comb begin
      lookup   = ascii_to_piece(data);
      is_piece = lookup[4];
      piece    = lookup[3:0];
      // '0' and '9' are deliberately not digits: they never form a legal run.
      is_digit = (data >= "1") && (data <= "8");
      count    = is_digit ? data[3:0] : 4'd0;
      is_slash = (data == "/");
      is_space = (data == " ");
      is_side  = (data == "w") || (data == "b");
      stm      = (data == "b");
   end

endmodule

// File: rtl/fen_placement_parser.sv
// FEN placement + side-to-move parser producing a 64-beat a8..h1 square stream.
module fen_placement_parser
   import chess_pkg::*;
#(
   parameter bit SKIP_TAIL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic       in_ready,
   output logic       out_pos_valid,
   output logic       out_pos_sop,
   output logic       out_pos_eop,
   output logic [3:0] out_pos_data,
   output logic       out_done,
   output logic       out_stm,
   output logic       out_err
);

   logic       is_piece, is_digit, is_slash, is_space, is_side, side_stm;
   piece_t     dec_piece;
   logic [3:0] count;

   fen_char_decode u_decode (
      .data     (in_data),
      .is_piece (is_piece),
      .piece    (dec_piece),
      .is_digit (is_digit),
      .count    (count),
      .is_slash (is_slash),
      .is_space (is_space),
      .is_side  (is_side),
      .stm      (side_stm)
   );

   fen_state_e state_q, state_d;
   logic [3:0] file_q, file_d;
   logic [2:0] rank_q, rank_d;
   logic [2:0] rem_q, rem_d;
   piece_t     pend_q, pend_d;
   logic       stm_q, stm_d;

   logic       accept, at_h1, fail, emit, emit_eop, done_d;
   piece_t     emit_piece;

   assign in_ready = (state_q != ST_EXPAND);
   assign accept   = in_valid && in_ready;
   // h1 is held back until the ' ' confirms the placement, so it can carry eop.
   assign at_h1    = (rank_q == 3'd7) && (file_q == 4'd7);

   always_comb begin
      state_d    = state_q;
      file_d     = file_q;
      rank_d     = rank_q;
      rem_d      = rem_q;
      pend_d     = pend_q;
      stm_d      = stm_q;
      fail       = 1'b0;
      emit       = 1'b0;
      emit_eop   = 1'b0;
      emit_piece = PT_EMPTY;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE, ST_PLACE: begin
            if (accept) begin
               if (in_last) begin
                  fail = 1'b1;
               end else if (is_piece) begin
                  if (file_q == 4'd8) begin
                     fail = 1'b1;
                  end else begin
                     file_d = file_q + 4'd1;
                     if (at_h1) begin
                        pend_d  = dec_piece;
                        state_d = ST_SPACE;
                     end else begin
                        emit       = 1'b1;
                        emit_piece = dec_piece;
                        state_d    = ST_PLACE;
                     end
                  end
               end else if (is_digit) begin
                  if (({1'b0, file_q} + {1'b0, count}) > 5'd8) begin
                     fail = 1'b1;
                  end else begin
                     file_d = file_q + 4'd1;
                     rem_d  = 3'(count - 4'd1);
                     if (at_h1) begin
                        pend_d  = PT_EMPTY;
                        state_d = ST_SPACE;
                     end else begin
                        emit    = 1'b1;
                        state_d = (count != 4'd1) ? ST_EXPAND : ST_PLACE;
                     end
                  end
               end else if (is_slash && (file_q == 4'd8) && (rank_q != 3'd7)) begin
                  rank_d  = rank_q + 3'd1;
                  file_d  = 4'd0;
                  state_d = ST_PLACE;
               end else begin
                  fail = 1'b1;
               end
            end
         end

         ST_EXPAND: begin
            file_d = file_q + 4'd1;
            rem_d  = rem_q - 3'd1;
            if (at_h1) begin
               pend_d  = PT_EMPTY;
               state_d = ST_SPACE;
            end else begin
               emit = 1'b1;
               if (rem_q == 3'd1) state_d = ST_PLACE;
            end
         end

         ST_SPACE: begin
            if (accept) begin
               if (is_space && !in_last) begin
                  emit       = 1'b1;
                  emit_eop   = 1'b1;
                  emit_piece = pend_q;
                  file_d     = 4'd0;
                  rank_d     = 3'd0;
                  state_d    = ST_SIDE;
               end else begin
                  fail = 1'b1;
               end
            end
         end

         ST_SIDE: begin
            if (accept) begin
               if (is_side && (SKIP_TAIL || in_last)) begin
                  done_d  = 1'b1;
                  stm_d   = side_stm;
                  state_d = in_last ? ST_IDLE : ST_TAIL;
               end else begin
                  fail = 1'b1;
               end
            end
         end

         ST_TAIL, ST_DRAIN: begin
            if (accept && in_last) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      if (fail) begin
         emit     = 1'b0;
         emit_eop = 1'b0;
         file_d   = 4'd0;
         rank_d   = 3'd0;
         rem_d    = 3'd0;
         state_d  = in_last ? ST_IDLE : ST_DRAIN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         file_q        <= 4'd0;
         rank_q        <= 3'd0;
         rem_q         <= 3'd0;
         pend_q        <= PT_EMPTY;
         stm_q         <= 1'b0;
         out_pos_valid <= 1'b0;
         out_pos_sop   <= 1'b0;
         out_pos_eop   <= 1'b0;
         out_pos_data  <= 4'd0;
         out_done      <= 1'b0;
         out_err       <= 1'b0;
      end else begin
         state_q       <= state_d;
         file_q        <= file_d;
         rank_q        <= rank_d;
         rem_q         <= rem_d;
         pend_q        <= pend_d;
         stm_q         <= stm_d;
         out_pos_valid <= emit;
         out_pos_sop   <= emit && (file_q == 4'd0) && (rank_q == 3'd0);
         out_pos_eop   <= emit_eop;
         out_pos_data  <= emit_piece;
         out_done      <= done_d;
         out_err       <= fail;
      end
   end

   assign out_stm = stm_q;

endmodule

// File: tb/tb_fen_placement_parser.sv
// Directed bench for fen_placement_parser: SKIP_TAIL=1 instance plus a SKIP_TAIL=0 instance.
module tb_fen_placement_parser;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       in_valid1, in_last1, in_ready1, pv1, ps1, pe1, done1, stm1, err1;
   logic [7:0] in_data1;
   logic [3:0] pd1;
   logic       in_valid0, in_last0, in_ready0, pv0, ps0, pe0, done0, stm0, err0;
   logic [7:0] in_data0;
   logic [3:0] pd0;

   fen_placement_parser #(.SKIP_TAIL(1'b1)) dut1 (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid1),
      .in_data       (in_data1),
      .in_last       (in_last1),
      .in_ready      (in_ready1),
      .out_pos_valid (pv1),
      .out_pos_sop   (ps1),
      .out_pos_eop   (pe1),
      .out_pos_data  (pd1),
      .out_done      (done1),
      .out_stm       (stm1),
      .out_err       (err1)
   );

   fen_placement_parser #(.SKIP_TAIL(1'b0)) dut0 (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid0),
      .in_data       (in_data0),
      .in_last       (in_last0),
      .in_ready      (in_ready0),
      .out_pos_valid (pv0),
      .out_pos_sop   (ps0),
      .out_pos_eop   (pe0),
      .out_pos_data  (pd0),
      .out_done      (done0),
      .out_stm       (stm0),
      .out_err       (err0)
   );

   logic [3:0] bdata [1024];
   bit         bsop  [1024];
   bit         beop  [1024];
   int nbeat = 0, ndone = 0, nerr = 0, nstall = 0, nacc = 0, nboth = 0;
   int ndone0 = 0, nerr0 = 0;

   always @(negedge clk) begin
      if (pv1 === 1'b1 && nbeat < 1024) begin
         bdata[nbeat] = pd1;
         bsop[nbeat]  = ps1;
         beop[nbeat]  = pe1;
         nbeat++;
      end
      if (done1 === 1'b1) ndone++;
      if (err1 === 1'b1) nerr++;
      if (done1 === 1'b1 && err1 === 1'b1) nboth++;
      if (in_ready1 === 1'b0) nstall++;
      if (in_valid1 === 1'b1 && in_ready1 === 1'b1) nacc++;
      if (done0 === 1'b1) ndone0++;
      if (err0 === 1'b1) nerr0++;
      if (done0 === 1'b1 && err0 === 1'b1) nboth++;
   end

   int npass = 0, ntot = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic send(input int sel, input logic [7:0] b, input bit last);
      bit ok = 1'b0;
      if (sel == 1) begin
         in_valid1 = 1'b1; in_data1 = b; in_last1 = last;
      end else begin
         in_valid0 = 1'b1; in_data0 = b; in_last0 = last;
      end
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (((sel == 1) ? in_ready1 : in_ready0) === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         ntot++;
         $error("FAIL send_timeout: observed in_ready stuck low, expected ready within 100 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_str(input int sel, input string s, input bit last);
      for (int i = 0; i < s.len(); i++) send(sel, s[i], last && (i == s.len() - 1));
   endtask

   task automatic idle(input int n);
      in_valid1 = 1'b0; in_last1 = 1'b0;
      in_valid0 = 1'b0; in_last0 = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int count_flags(input int base, input int n, input bit eop);
      int c = 0;
      for (int i = base; i < base + n && i < 1024; i++) c += eop ? int'(beop[i]) : int'(bsop[i]);
      return c;
   endfunction

   int b, d, e, s, a;
   int orv;

   initial begin
      rst = 1'b1;
      in_valid1 = 1'b0; in_data1 = 8'h00; in_last1 = 1'b0;
      in_valid0 = 1'b0; in_data0 = 8'h00; in_last0 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(in_ready1), 1);
      chk("rst_outputs", int'({pv1, ps1, pe1, pd1, done1, stm1, err1}), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Start position, tail skipped.
      b = nbeat; d = ndone; e = nerr; s = nstall;
      send_str(1, "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1", 1'b1);
      idle(3);
      chk("start_beats", nbeat - b, 64);
      chk("start_beat0", int'(bdata[b]), 12);
      chk("start_sop0", int'(bsop[b]), 1);
      chk("start_bpawn", int'(bdata[b + 8]), 9);
      chk("start_wking", int'(bdata[b + 60]), 6);
      chk("start_beat63", int'(bdata[b + 63]), 4);
      chk("start_eop63", int'(beop[b + 63]), 1);
      chk("start_nsop", count_flags(b, 64, 1'b0), 1);
      chk("start_neop", count_flags(b, 64, 1'b1), 1);
      chk("start_done", ndone - d, 1);
      chk("start_err", nerr - e, 0);
      chk("start_stm", int'(stm1), 0);
      chk("start_stall", nstall - s, 28);

      // Empty board, black to move, in_valid held high.
      b = nbeat; d = ndone; s = nstall; a = nacc;
      send_str(1, "8/8/8/8/8/8/8/8 b", 1'b1);
      idle(3);
      orv = 0;
      for (int i = b; i < b + 64; i++) orv |= int'(bdata[i]);
      chk("empty_beats", nbeat - b, 64);
      chk("empty_data", orv, 0);
      chk("empty_sop0", int'(bsop[b]), 1);
      chk("empty_eop63", int'(beop[b + 63]), 1);
      chk("empty_done", ndone - d, 1);
      chk("empty_stm", int'(stm1), 1);
      chk("empty_accepted", nacc - a, 17);
      chk("empty_stall", nstall - s, 56);

      // Illegal digit '9': error next cycle, remaining bytes drained.
      b = nbeat; d = ndone; e = nerr;
      send_str(1, "rnbqkbnr/", 1'b0);
      send(1, "9", 1'b0);
      chk("err9_pulse", int'(err1), 1);
      chk("err9_novalid", int'(pv1), 0);
      send_str(1, "/8 w", 1'b1);
      idle(3);
      chk("err9_beats", nbeat - b, 8);
      chk("err9_count", nerr - e, 1);
      chk("err9_nodone", ndone - d, 0);
      chk("err9_noeop", count_flags(b, 8, 1'b1), 0);
      b = nbeat; d = ndone;
      send_str(1, "8/8/8/8/8/8/8/8 w", 1'b1);
      idle(3);
      chk("after9_beats", nbeat - b, 64);
      chk("after9_sop0", int'(bsop[b]), 1);
      chk("after9_done", ndone - d, 1);
      chk("after9_stm", int'(stm1), 0);

      // Too few ranks: ' ' arrives at rank 1.
      b = nbeat; d = ndone; e = nerr;
      send_str(1, "4k3/8 w", 1'b1);
      idle(3);
      chk("short_beats", nbeat - b, 16);
      chk("short_err", nerr - e, 1);
      chk("short_nodone", ndone - d, 0);
      chk("short_noeop", count_flags(b, 16, 1'b1), 0);
      chk("short_ready", int'(in_ready1), 1);

      // Reset during expansion of an '8', after three beats.
      b = nbeat; d = ndone; e = nerr;
      send(1, "8", 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      @(negedge clk);
      #1;
      rst = 1'b1;
      in_valid1 = 1'b0; in_last1 = 1'b0;
      #1;
      chk("rst_mid_valid", int'(pv1), 0);
      chk("rst_mid_ready", int'(in_ready1), 1);
      chk("rst_mid_beats", nbeat - b, 3);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      b = nbeat;
      send_str(1, "8/8/8/8/8/8/8/8 w", 1'b1);
      idle(3);
      chk("rst_next_beats", nbeat - b, 64);
      chk("rst_next_sop0", int'(bsop[b]), 1);
      chk("rst_next_done", ndone - d, 1);
      chk("rst_next_noerr", nerr - e, 0);

      // Piece past file h, digit overflow, and in_last inside the placement.
      b = nbeat; e = nerr;
      send_str(1, "rnbqkbnrp w", 1'b1);
      idle(3);
      chk("ovf_piece_beats", nbeat - b, 8);
      chk("ovf_piece_err", nerr - e, 1);
      b = nbeat; e = nerr;
      send_str(1, "k8 w", 1'b1);
      idle(3);
      chk("ovf_digit_beats", nbeat - b, 1);
      chk("ovf_digit_err", nerr - e, 1);
      b = nbeat; e = nerr; d = ndone;
      send_str(1, "8/8/", 1'b1);
      idle(3);
      chk("early_last_beats", nbeat - b, 16);
      chk("early_last_err", nerr - e, 1);
      send_str(1, "8/8/8/8/8/8/8/8 b", 1'b1);
      idle(3);
      chk("early_last_recover", ndone - d, 1);

      // SKIP_TAIL=0: tail after side char is an error.
      d = ndone0; e = nerr0;
      send_str(0, "8/8/8/8/8/8/8/8 w KQ", 1'b1);
      idle(3);
      chk("notail_err", nerr0 - e, 1);
      chk("notail_nodone", ndone0 - d, 0);
      send_str(0, "8/8/8/8/8/8/8/8 w", 1'b1);
      idle(3);
      chk("notail_done", ndone0 - d, 1);
      chk("notail_err_total", nerr0 - e, 1);
      chk("notail_stm", int'(stm0), 0);

      chk("done_err_exclusive", nboth, 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
